// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller:
// stage register fields flow in, forward selects and stall controls flow out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_D, rt_D, rs_E, rt_E;
    logic [4:0]       WriteReg_E, WriteReg_M, WriteReg_W;
    logic             RegWrite_E, MemtoReg_E;
    logic             RegWrite_M, MemtoReg_M;
    logic             RegWrite_W;
    logic             Branch_D, MduUse_D, MduStart_E, MduDiv_E;
    logic [1:0]       ForwardA_E, ForwardB_E;
    logic             ForwardA_D, ForwardB_D;
    logic             Stall_F, Stall_D, Flush_E;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_D, rt_D, rs_E, rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
               RegWrite_E, MemtoReg_E, RegWrite_M, MemtoReg_M, RegWrite_W,
               Branch_D, MduUse_D, MduStart_E, MduDiv_E,
        input  ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D,
               Stall_F, Stall_D, Flush_E, mdu_busy, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, rs_E, rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
               RegWrite_E, MemtoReg_E, RegWrite_M, MemtoReg_M, RegWrite_W,
               Branch_D, MduUse_D, MduStart_E, MduDiv_E,
        output ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D,
               Stall_F, Stall_D, Flush_E, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: operand forwarding selects,
// load-use / branch / mult-div stalls, HI/LO busy tracking and a stall counter.
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hif
);
    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MDU_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    mdu_state_t       r_state, w_state_nxt;
    logic [MDU_W-1:0] r_mdu_cnt, w_mdu_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_mdu_busy;
    logic       w_lw_stall, w_br_stall, w_mdu_stall, w_stall;
    logic [1:0] w_fwd_a_e, w_fwd_b_e;
    logic       w_fwd_a_d, w_fwd_b_d;

    // Register $0 is hard-wired, so a destination of 0 never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src,
                                         input logic       wr_m, input logic [4:0] dst_m,
                                         input logic       wr_w, input logic [4:0] dst_w);
        if (wr_m && reg_hit(dst_m, src))      return 2'b10;
        else if (wr_w && reg_hit(dst_w, src)) return 2'b01;
        else                                  return 2'b00;
    endfunction

    always_comb begin
        w_fwd_a_e = fwd_e(hif.rs_E, hif.RegWrite_M, hif.WriteReg_M, hif.RegWrite_W, hif.WriteReg_W);
        w_fwd_b_e = fwd_e(hif.rt_E, hif.RegWrite_M, hif.WriteReg_M, hif.RegWrite_W, hif.WriteReg_W);
        w_fwd_a_d = hif.RegWrite_M && !hif.MemtoReg_M && reg_hit(hif.WriteReg_M, hif.rs_D);
        w_fwd_b_d = hif.RegWrite_M && !hif.MemtoReg_M && reg_hit(hif.WriteReg_M, hif.rt_D);
    end

    always_comb begin
        w_lw_stall  = hif.MemtoReg_E && hif.RegWrite_E &&
                      (reg_hit(hif.WriteReg_E, hif.rs_D) || reg_hit(hif.WriteReg_E, hif.rt_D));
        w_br_stall  = hif.Branch_D &&
                      ((hif.RegWrite_E &&
                        (reg_hit(hif.WriteReg_E, hif.rs_D) || reg_hit(hif.WriteReg_E, hif.rt_D))) ||
                       (hif.MemtoReg_M &&
                        (reg_hit(hif.WriteReg_M, hif.rs_D) || reg_hit(hif.WriteReg_M, hif.rt_D))));
        w_mdu_stall = hif.MduUse_D && (w_mdu_busy || hif.MduStart_E);
        w_stall     = w_lw_stall || w_br_stall || w_mdu_stall;
    end

    assign w_mdu_busy = (r_state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mdu_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mdu_cnt <= w_mdu_cnt_nxt;
        end
    end

    // A start while BUSY cannot legally happen (mdu_stall holds it back) and is ignored.
    always_comb begin
        w_state_nxt   = r_state;
        w_mdu_cnt_nxt = r_mdu_cnt;
        unique case (r_state)
            IDLE: begin
                if (hif.MduStart_E) begin
                    w_state_nxt   = BUSY;
                    w_mdu_cnt_nxt = hif.MduDiv_E ? MDU_W'(DIV_LAT) : MDU_W'(MULT_LAT);
                end
            end
            BUSY: begin
                w_mdu_cnt_nxt = r_mdu_cnt - MDU_W'(1);
                if (r_mdu_cnt == MDU_W'(1)) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mdu_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                             r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != '1)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    // Every output reads as zero while reset is held, including mid mult/div.
    assign hif.ForwardA_E = rst_n ? w_fwd_a_e : 2'b00;
    assign hif.ForwardB_E = rst_n ? w_fwd_b_e : 2'b00;
    assign hif.ForwardA_D = rst_n & w_fwd_a_d;
    assign hif.ForwardB_D = rst_n & w_fwd_b_d;
    assign hif.Stall_F    = rst_n & w_stall;
    assign hif.Stall_D    = rst_n & w_stall;
    assign hif.Flush_E    = rst_n & w_stall;
    assign hif.mdu_busy   = rst_n & w_mdu_busy;
    assign hif.stall_cnt  = rst_n ? r_stall_cnt : '0;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a
// negedge monitor pops and compares them against the live outputs.
module tb_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs_D, rt_D, rs_E, rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
        logic       RegWrite_E, MemtoReg_E, RegWrite_M, MemtoReg_M, RegWrite_W;
        logic       Branch_D, MduUse_D, MduStart_E, MduDiv_E;
    } vin_t;

    typedef struct packed {
        logic [1:0]       fa_e, fb_e;
        logic             fa_d, fb_d, stall, busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   vec_no = 0;
    int   exp_cnt = 0;
    exp_t sb_q[$];
    exp_t m_x;
    vin_t v;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif.slave)
    );

    function automatic vin_t idle();
        vin_t t;
        t       = '0;
        t.rst_n = 1'b1;
        return t;
    endfunction

    function automatic exp_t ex(input int fa_e, input int fb_e, input int fa_d,
                                input int fb_d, input int stall, input int busy);
        exp_t t;
        t       = '0;
        t.fa_e  = 2'(fa_e);
        t.fb_e  = 2'(fb_e);
        t.fa_d  = 1'(fa_d);
        t.fb_d  = 1'(fb_d);
        t.stall = 1'(stall);
        t.busy  = 1'(busy);
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, vec_no, act, exp);
        end
    endtask

    task automatic apply(input vin_t vi);
        rst_n          = vi.rst_n;
        hif.rs_D       = vi.rs_D;
        hif.rt_D       = vi.rt_D;
        hif.rs_E       = vi.rs_E;
        hif.rt_E       = vi.rt_E;
        hif.WriteReg_E = vi.WriteReg_E;
        hif.WriteReg_M = vi.WriteReg_M;
        hif.WriteReg_W = vi.WriteReg_W;
        hif.RegWrite_E = vi.RegWrite_E;
        hif.MemtoReg_E = vi.MemtoReg_E;
        hif.RegWrite_M = vi.RegWrite_M;
        hif.MemtoReg_M = vi.MemtoReg_M;
        hif.RegWrite_W = vi.RegWrite_W;
        hif.Branch_D   = vi.Branch_D;
        hif.MduUse_D   = vi.MduUse_D;
        hif.MduStart_E = vi.MduStart_E;
        hif.MduDiv_E   = vi.MduDiv_E;
    endtask

    // One cycle of stimulus; stall_cnt expectation tracks stalls seen so far.
    task automatic step(input vin_t vi, input exp_t ei);
        @(posedge clk);
        #1;
        apply(vi);
        ei.cnt = vi.rst_n ? CNT_W'(exp_cnt) : '0;
        sb_q.push_back(ei);
        if (!vi.rst_n)                     exp_cnt = 0;
        else if (ei.stall && exp_cnt < SAT) exp_cnt++;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            m_x = sb_q.pop_front();
            vec_no++;
            chk("ForwardA_E", int'(hif.ForwardA_E), int'(m_x.fa_e));
            chk("ForwardB_E", int'(hif.ForwardB_E), int'(m_x.fb_e));
            chk("ForwardA_D", int'(hif.ForwardA_D), int'(m_x.fa_d));
            chk("ForwardB_D", int'(hif.ForwardB_D), int'(m_x.fb_d));
            chk("Stall_F",    int'(hif.Stall_F),    int'(m_x.stall));
            chk("Stall_D",    int'(hif.Stall_D),    int'(m_x.stall));
            chk("Flush_E",    int'(hif.Flush_E),    int'(m_x.stall));
            chk("mdu_busy",   int'(hif.mdu_busy),   int'(m_x.busy));
            chk("stall_cnt",  int'(hif.stall_cnt),  int'(m_x.cnt));
            if (hif.MduStart_E) chk("start_while_busy", int'(hif.mdu_busy), 0);
        end
    end

    initial begin
        v = idle();
        v.rst_n = 1'b0;
        apply(v);

        // Reset with live hazards on the inputs: outputs gated to zero.
        v.RegWrite_M = 1'b1; v.WriteReg_M = 5'd8; v.rs_E = 5'd8; v.rs_D = 5'd8; v.MduUse_D = 1'b1;
        step(v, ex(0, 0, 0, 0, 0, 0));
        step(v, ex(0, 0, 0, 0, 0, 0));

        // E/D forwarding, M over W priority, $0 never matches.
        v = idle();
        v.RegWrite_M = 1'b1; v.WriteReg_M = 5'd8; v.RegWrite_W = 1'b1; v.WriteReg_W = 5'd8;
        v.rs_E = 5'd8; v.rt_E = 5'd8; v.rs_D = 5'd8;
        step(v, ex(2, 2, 1, 0, 0, 0));
        v.RegWrite_M = 1'b0;
        step(v, ex(1, 1, 0, 0, 0, 0));
        v = idle();
        v.RegWrite_M = 1'b1; v.RegWrite_W = 1'b1;
        step(v, ex(0, 0, 0, 0, 0, 0));
        v = idle();
        v.RegWrite_W = 1'b1; v.WriteReg_W = 5'd5; v.rt_E = 5'd5;
        v.RegWrite_M = 1'b1; v.WriteReg_M = 5'd3; v.rs_E = 5'd3; v.rt_D = 5'd3;
        step(v, ex(2, 1, 0, 1, 0, 0));

        // Load-use: stall while load in E, none once it reaches M, W-forward after.
        v = idle();
        v.MemtoReg_E = 1'b1; v.RegWrite_E = 1'b1; v.WriteReg_E = 5'd9; v.rt_D = 5'd9;
        step(v, ex(0, 0, 0, 0, 1, 0));
        v = idle();
        v.RegWrite_M = 1'b1; v.MemtoReg_M = 1'b1; v.WriteReg_M = 5'd9; v.rt_D = 5'd9;
        step(v, ex(0, 0, 0, 0, 0, 0));
        v = idle();
        v.RegWrite_W = 1'b1; v.WriteReg_W = 5'd9; v.rt_E = 5'd9;
        step(v, ex(0, 1, 0, 0, 0, 0));
        v = idle();
        v.MemtoReg_E = 1'b1; v.RegWrite_E = 1'b1;
        step(v, ex(0, 0, 0, 0, 0, 0));

        // Branch compare hazards.
        v = idle();
        v.Branch_D = 1'b1; v.rs_D = 5'd4; v.RegWrite_E = 1'b1; v.WriteReg_E = 5'd4;
        step(v, ex(0, 0, 0, 0, 1, 0));
        v = idle();
        v.Branch_D = 1'b1; v.rs_D = 5'd4; v.RegWrite_M = 1'b1; v.WriteReg_M = 5'd4;
        step(v, ex(0, 0, 1, 0, 0, 0));
        v.MemtoReg_M = 1'b1;
        step(v, ex(0, 0, 0, 0, 1, 0));
        v.Branch_D = 1'b0;
        step(v, ex(0, 0, 0, 0, 0, 0));
        v = idle();
        v.Branch_D = 1'b1; v.rt_D = 5'd4; v.WriteReg_E = 5'd4;
        step(v, ex(0, 0, 0, 0, 0, 0));

        // Divide with mfhi waiting in D: stalls from the start cycle for 11 cycles.
        v = idle();
        v.MduStart_E = 1'b1; v.MduDiv_E = 1'b1; v.MduUse_D = 1'b1;
        step(v, ex(0, 0, 0, 0, 1, 0));
        v = idle();
        v.MduUse_D = 1'b1;
        for (int i = 0; i < 10; i++) step(v, ex(0, 0, 0, 0, 1, 1));
        step(v, ex(0, 0, 0, 0, 0, 0));

        // Multiply: busy exactly 5 cycles; mfhi arrives on the last busy cycle.
        v = idle();
        v.MduStart_E = 1'b1;
        step(v, ex(0, 0, 0, 0, 0, 0));
        v = idle();
        for (int i = 0; i < 4; i++) step(v, ex(0, 0, 0, 0, 0, 1));
        v.MduUse_D = 1'b1;
        step(v, ex(0, 0, 0, 0, 1, 1));
        step(v, ex(0, 0, 0, 0, 0, 0));

        // Reset 3 cycles into a divide: busy drops and stays low.
        v = idle();
        v.MduStart_E = 1'b1; v.MduDiv_E = 1'b1;
        step(v, ex(0, 0, 0, 0, 0, 0));
        v = idle();
        for (int i = 0; i < 3; i++) step(v, ex(0, 0, 0, 0, 0, 1));
        v.rst_n = 1'b0; v.MduUse_D = 1'b1;
        v.RegWrite_M = 1'b1; v.WriteReg_M = 5'd8; v.rs_E = 5'd8; v.rs_D = 5'd8;
        step(v, ex(0, 0, 0, 0, 0, 0));
        step(v, ex(0, 0, 0, 0, 0, 0));
        v = idle();
        v.MduUse_D = 1'b1;
        for (int i = 0; i < 12; i++) step(v, ex(0, 0, 0, 0, 0, 0));

        // Continuous load-use stall for 2^CNT_W+5 cycles: counter saturates.
        v = idle();
        v.MemtoReg_E = 1'b1; v.RegWrite_E = 1'b1; v.WriteReg_E = 5'd7; v.rs_D = 5'd7;
        for (int i = 0; i < SAT + 6; i++) step(v, ex(0, 0, 0, 0, 1, 0));
        v = idle();
        step(v, ex(0, 0, 0, 0, 0, 0));
        step(v, ex(0, 0, 0, 0, 0, 0));

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
